// File: rtl/core_seq_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encodings,
// next-PC select codes and the SYSTEM opcode.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_MEM   = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd6,
    ST_FAULT = 3'd7
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JAL = 2'b10;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // jal outranks a taken branch when both decode flags are set
  function automatic logic [1:0] next_pc_sel(input logic jal, input logic branch,
                                             input logic taken);
    if (jal)
      return PC_SEL_JAL;
    else if (branch && taken)
      return PC_SEL_BR;
    else
      return PC_SEL_SEQ;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive un-acknowledged request cycles; expired flags the last
// allowed cycle passing without an ack so the FSM can fault on that edge.
module seq_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear || ack)
      count <= '0;
    else if (active && count != LIMIT)
      count <= count + 1'b1;
  end

  // count holds the number of earlier missed cycles, so LAST means this is
  // request cycle MEM_TIMEOUT; an ack in this very cycle is still accepted
  assign expired = active && !ack && (count == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: BOOT delay, then FETCH/EXEC/[MEM]/WB per
// instruction with memory handshakes, timeout FAULT and SYSTEM-opcode HALT.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instruction,
  input  logic        wenb,
  input  logic        load_enb,
  input  logic        store_enb,
  input  logic        branch_enb,
  input  logic        jal_enb,
  input  logic        branch_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        reg_wen,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  state_e        cur_state;
  state_e        nxt_state;
  logic [BW-1:0] boot_count;
  logic          timer_clear;
  logic          timer_ack;
  logic          expired;
  logic          unused_instr;

  assign unused_instr = ^instruction[31:7];

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_BOOT:  if (boot_count == BOOT_LAST) nxt_state = ST_IDLE;
      ST_IDLE:  if (run) nxt_state = ST_FETCH;
      ST_FETCH: begin
        if (expired)
          nxt_state = ST_FAULT;
        else if (imem_ack)
          nxt_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (instruction[6:0] == OPC_SYSTEM)
          nxt_state = ST_HALT;
        else if (load_enb && store_enb)
          nxt_state = ST_FAULT;
        else if (load_enb || store_enb)
          nxt_state = ST_MEM;
        else
          nxt_state = ST_WB;
      end
      ST_MEM: begin
        if (expired)
          nxt_state = ST_FAULT;
        else if (dmem_ack)
          nxt_state = ST_WB;
      end
      ST_WB:    nxt_state = run ? ST_FETCH : ST_IDLE;
      default:  nxt_state = cur_state;
    endcase
  end

  // Acks only count while the matching request is being presented
  assign timer_ack   = (cur_state == ST_FETCH && imem_ack) ||
                       (cur_state == ST_MEM && dmem_ack);
  assign timer_clear = (nxt_state == ST_FETCH && cur_state != ST_FETCH) ||
                       (nxt_state == ST_MEM && cur_state != ST_MEM);

  seq_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .active (imem_req || dmem_req),
    .ack    (timer_ack),
    .expired(expired)
  );

  // Outputs are registered from the next state, so each one lines up with the
  // state register and no ack reaches an output within the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state  <= ST_BOOT;
      boot_count <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      pc_write   <= 1'b0;
      pc_sel     <= PC_SEL_SEQ;
      reg_wen    <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == ST_BOOT && boot_count != BOOT_LAST)
        boot_count <= boot_count + 1'b1;
      imem_req <= (nxt_state == ST_FETCH);
      dmem_req <= (nxt_state == ST_MEM);
      dmem_we  <= (nxt_state == ST_MEM) && store_enb;
      pc_write <= (nxt_state == ST_WB);
      reg_wen  <= (nxt_state == ST_WB) && (wenb || load_enb) && !store_enb;
      pc_sel   <= (nxt_state == ST_WB) ? next_pc_sel(jal_enb, branch_enb, branch_taken)
                                       : PC_SEL_SEQ;
      halted   <= (nxt_state == ST_HALT);
      fault    <= (nxt_state == ST_FAULT);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: builds an expected per-cycle output timeline for
// each instruction from its flags and wait counts, then replays it on the DUT.
module tb_core_sequencer;

  localparam int BOOT = 4;
  localparam int TMO  = 15;

  localparam logic [2:0] S_BOOT = 3'd0, S_IDLE = 3'd1, S_FETCH = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;
  localparam logic [6:0] OPC_SYS = 7'b1110011;
  localparam logic [6:0] OPC_ALU = 7'h33;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instruction = '0;
  logic        wenb = 1'b0, load_enb = 1'b0, store_enb = 1'b0;
  logic        branch_enb = 1'b0, jal_enb = 1'b0, branch_taken = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, pc_write, reg_wen, halted, fault;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [11:0] obs;

  core_sequencer #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .wenb(wenb), .load_enb(load_enb), .store_enb(store_enb),
    .branch_enb(branch_enb), .jal_enb(jal_enb), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .pc_sel(pc_sel), .reg_wen(reg_wen),
    .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {imem_req, dmem_req, dmem_we, pc_write, pc_sel, reg_wen, halted, fault, state};

  // One cycle of the expected timeline: inputs to drive and outputs to expect
  typedef struct packed {
    logic        run;
    logic [31:0] ins;
    logic [5:0]  fl;   // {wenb, load, store, branch, jal, taken}
    logic        iack;
    logic        dack;
    logic [11:0] expv;
  } step_t;

  step_t plan_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic logic rb();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic logic [11:0] vec(input logic im, input logic dm, input logic we,
                                      input logic pw, input logic [1:0] sel, input logic rw,
                                      input logic h, input logic f, input logic [2:0] st);
    return {im, dm, we, pw, sel, rw, h, f, st};
  endfunction

  task automatic apply(input step_t e);
    run = e.run;
    instruction = e.ins;
    {wenb, load_enb, store_enb, branch_enb, jal_enb, branch_taken} = e.fl;
    imem_ack = e.iack;
    dmem_ack = e.dack;
  endtask

  task automatic push_term(input step_t base, input logic [2:0] st);
    step_t e = base;
    for (int k = 0; k < 5; k++) begin
      e.run = rb(); e.iack = rb(); e.dack = rb();
      e.expv = vec(0, 0, 0, 0, 2'b00, 0, st == S_HALT, st == S_FAULT, st);
      plan_q.push_back(e);
    end
  endtask

  // Reference model: expected cycles of one instruction starting in FETCH.
  // fw/mw = wait cycles before the ack; run_wb = run level seen in WB.
  task automatic plan_instr(input logic [6:0] opc, input logic [5:0] fl, input int fw,
                            input int mw, input logic run_wb);
    step_t e;
    logic w, l, s, b, j, t;
    logic [1:0] sel;
    int nf, nm, ni;
    {w, l, s, b, j, t} = fl;
    e.ins = $urandom;
    e.ins[6:0] = opc;
    e.fl = fl;
    nf = (fw < TMO) ? fw + 1 : TMO;
    for (int c = 0; c < nf; c++) begin
      e.run = rb(); e.iack = (c == fw); e.dack = rb();
      e.expv = vec(1, 0, 0, 0, 2'b00, 0, 0, 0, S_FETCH);
      plan_q.push_back(e);
    end
    if (fw >= TMO) begin push_term(e, S_FAULT); return; end
    e.run = run_wb ? rb() : 1'b0; e.iack = rb(); e.dack = rb();
    e.expv = vec(0, 0, 0, 0, 2'b00, 0, 0, 0, S_EXEC);
    plan_q.push_back(e);
    if (opc == OPC_SYS) begin push_term(e, S_HALT); return; end
    if (l && s) begin push_term(e, S_FAULT); return; end
    if (l || s) begin
      nm = (mw < TMO) ? mw + 1 : TMO;
      for (int c = 0; c < nm; c++) begin
        e.run = run_wb ? rb() : 1'b0; e.iack = rb(); e.dack = (c == mw);
        e.expv = vec(0, 1, s, 0, 2'b00, 0, 0, 0, S_MEM);
        plan_q.push_back(e);
      end
      if (mw >= TMO) begin push_term(e, S_FAULT); return; end
    end
    sel = j ? 2'b10 : ((b && t) ? 2'b01 : 2'b00);
    e.run = run_wb; e.iack = rb(); e.dack = rb();
    e.expv = vec(0, 0, 0, 1, sel, (w || l) && !s, 0, 0, S_WB);
    plan_q.push_back(e);
    if (!run_wb) begin
      ni = $urandom_range(0, 2);
      for (int k = 0; k <= ni; k++) begin
        e.run = (k == ni); e.iack = rb(); e.dack = rb();
        e.expv = vec(0, 0, 0, 0, 2'b00, 0, 0, 0, S_IDLE);
        plan_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b1; #1;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++; $display("FAIL reset_assert: outputs=%h expected=%h", obs, 12'h000);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++; $display("FAIL reset_hold: outputs=%h expected=%h", obs, 12'h000);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < BOOT; k++) begin
      n_checks++;
      if (obs !== vec(0, 0, 0, 0, 2'b00, 0, 0, 0, S_BOOT)) begin
        n_fail++; $display("FAIL boot cycle %0d: outputs=%h expected=%h", k, obs, 12'h000);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (obs !== vec(0, 0, 0, 0, 2'b00, 0, 0, 0, S_IDLE)) begin
      n_fail++; $display("FAIL boot_idle: outputs=%h expected=%h", obs,
                         vec(0, 0, 0, 0, 2'b00, 0, 0, 0, S_IDLE));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    step_t e;
    int cyc = 0;
    for (int i = 0; i < 3; i++) plan_instr(OPC_ALU, 6'b100000, 0, 0, 1'b1);
    while (plan_q.size() != 0) begin
      e = plan_q.pop_front(); apply(e); n_checks++;
      if (obs !== e.expv) begin
        n_fail++; $display("FAIL alu cycle %0d: outputs=%h expected=%h", cyc, obs, e.expv);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    step_t e;
    int cyc = 0;
    plan_instr(7'h03, 6'b010000, 0, 2, 1'b1);
    plan_instr(7'h23, 6'b101000, 0, 0, 1'b1);
    plan_instr(7'h03, 6'b110000, 1, 0, 1'b1);
    while (plan_q.size() != 0) begin
      e = plan_q.pop_front(); apply(e); n_checks++;
      if (obs !== e.expv) begin
        n_fail++; $display("FAIL load_store cycle %0d: outputs=%h expected=%h", cyc, obs, e.expv);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jal();
    step_t e;
    int cyc = 0;
    plan_instr(7'h63, 6'b000101, 0, 0, 1'b1);
    plan_instr(7'h6f, 6'b100111, 0, 0, 1'b1);
    plan_instr(7'h63, 6'b000100, 1, 0, 1'b1);
    plan_instr(7'h6f, 6'b100010, 0, 0, 1'b1);
    while (plan_q.size() != 0) begin
      e = plan_q.pop_front(); apply(e); n_checks++;
      if (obs !== e.expv) begin
        n_fail++; $display("FAIL branch_jal cycle %0d: outputs=%h expected=%h", cyc, obs, e.expv);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    step_t e;
    int cyc = 0;
    logic [6:0] opc;
    logic [5:0] fl;
    for (int i = 0; i < 30; i++) begin
      opc = 7'($urandom);
      if (opc == OPC_SYS) opc = OPC_ALU;
      fl = 6'($urandom);
      if (fl[4] && fl[3]) fl[$urandom_range(3, 4)] = 1'b0;
      plan_instr(opc, fl, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
    end
    while (plan_q.size() != 0) begin
      e = plan_q.pop_front(); apply(e); n_checks++;
      if (obs !== e.expv) begin
        n_fail++; $display("FAIL random cycle %0d: outputs=%h expected=%h", cyc, obs, e.expv);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_run();
    step_t e;
    int cyc = 0;
    plan_instr(7'h03, 6'b010000, 0, 2, 1'b0);
    plan_instr(OPC_ALU, 6'b100000, 0, 0, 1'b0);
    plan_instr(OPC_SYS, 6'($urandom), 0, 0, 1'b1);
    while (plan_q.size() != 0) begin
      e = plan_q.pop_front(); apply(e); n_checks++;
      if (obs !== e.expv) begin
        n_fail++; $display("FAIL halt_run cycle %0d: outputs=%h expected=%h", cyc, obs, e.expv);
      end
      cyc++; @(posedge clk); #1;
    end
    test_reset();
  endtask

  task automatic test_illegal();
    step_t e;
    int cyc = 0;
    plan_instr(OPC_ALU, 6'b011000, 0, 0, 1'b1);
    while (plan_q.size() != 0) begin
      e = plan_q.pop_front(); apply(e); n_checks++;
      if (obs !== e.expv) begin
        n_fail++; $display("FAIL illegal cycle %0d: outputs=%h expected=%h", cyc, obs, e.expv);
      end
      cyc++; @(posedge clk); #1;
    end
    test_reset();
  endtask

  task automatic test_timeout();
    step_t e;
    int cyc = 0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        plan_instr(OPC_ALU, 6'b100000, TMO - 1, 0, 1'b1);
        plan_instr(7'h23, 6'b001000, 0, TMO - 1, 1'b1);
        plan_instr(7'h03, 6'b010000, 0, TMO, 1'b1);
      end else begin
        plan_instr(OPC_ALU, 6'b100000, TMO, 0, 1'b1);
      end
      while (plan_q.size() != 0) begin
        e = plan_q.pop_front(); apply(e); n_checks++;
        if (obs !== e.expv) begin
          n_fail++; $display("FAIL timeout cycle %0d: outputs=%h expected=%h", cyc, obs, e.expv);
        end
        cyc++; @(posedge clk); #1;
      end
      #3 reset = 1'b0;
      #1;
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++; $display("FAIL fault_async_reset: outputs=%h expected=%h", obs, 12'h000);
      end
      test_reset();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jal();
    test_random();
    test_halt_run();
    test_illegal();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
